csync_gen: RTL and testbench



---
 rtl/csync_gen_if.sv | 24 ++
 rtl/csync_gen.sv | 104 ++++++++++
 tb/tb_csync_gen.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/csync_gen_if.sv
// Signal bundle between the pong video timing generator and its consumers:
// tick enable and game pixel in, composite sync, gated video and raster position out.
interface csync_gen_if;
  logic       ce;
  logic       v_in;
  logic       csync;
  logic       v_out;
  logic [7:0] hcount;
  logic [9:0] vcount;
  logic       hblank;
  logic       vblank;
  logic       line_start;
  logic       frame_start;

  modport master (
    output ce, v_in,
    input  csync, v_out, hcount, vcount, hblank, vblank, line_start, frame_start
  );

  modport slave (
    input  ce, v_in,
    output csync, v_out, hcount, vcount, hblank, vblank, line_start, frame_start
  );
endinterface

// File: rtl/csync_gen.sv
// Composite-video timing generator for the 2 MHz pong domain: raster counters,
// composite sync with long vsync pulses, blanking flags, gated video and strobes.
module csync_gen #(
  parameter int unsigned H_TOTAL      = 128,
  parameter int unsigned H_SYNC       = 8,
  parameter int unsigned H_VIS_START  = 12,
  parameter int unsigned V_TOTAL      = 262,
  parameter int unsigned V_SYNC_START = 258,
  parameter int unsigned V_SYNC_LINES = 3,
  parameter int unsigned V_VIS_START  = 13,
  parameter int unsigned V_VIS_END    = 258
) (
  input logic         clkvideo,
  input logic         reset,
  csync_gen_if.slave  bus
);

  localparam logic [7:0] H_LAST      = 8'(H_TOTAL - 1);
  localparam logic [7:0] H_SYNC_END  = 8'(H_SYNC);
  // Vsync lines stay low until H_SYNC ticks before the line end, giving one long pulse per line.
  localparam logic [7:0] H_VS_END    = 8'(H_TOTAL - H_SYNC);
  localparam logic [7:0] H_VIS       = 8'(H_VIS_START);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VS_FIRST  = 10'(V_SYNC_START);
  localparam logic [9:0] V_VS_END    = 10'(V_SYNC_START + V_SYNC_LINES);
  localparam logic [9:0] V_VIS_FIRST = 10'(V_VIS_START);
  localparam logic [9:0] V_VIS_LAST  = 10'(V_VIS_END);

  logic [7:0] hcount_r;
  logic [9:0] vcount_r;
  logic       csync_r;
  logic       v_out_r;
  logic       hblank_r;
  logic       vblank_r;
  logic       line_start_r;
  logic       frame_start_r;

  logic       in_vsync_s;
  logic       hblank_s;
  logic       vblank_s;
  logic       csync_s;
  logic       video_s;

  // Decode of the current raster position into next-tick output values
  always_comb begin
    in_vsync_s = (vcount_r >= V_VS_FIRST) && (vcount_r < V_VS_END);
    hblank_s   = (hcount_r < H_VIS);
    vblank_s   = (vcount_r < V_VIS_FIRST) || (vcount_r >= V_VIS_LAST);
    if (in_vsync_s) begin
      csync_s = (hcount_r >= H_VS_END);
    end else begin
      csync_s = (hcount_r >= H_SYNC_END);
    end
    video_s = bus.v_in & ~hblank_s & ~vblank_s;
  end

  // Raster counters: hcount every tick, vcount on the hcount wrap
  always_ff @(posedge clkvideo or posedge reset) begin
    if (reset) begin
      hcount_r <= 8'd0;
      vcount_r <= 10'd0;
    end else if (bus.ce) begin
      if (hcount_r == H_LAST) begin
        hcount_r <= 8'd0;
        if (vcount_r == V_LAST) begin
          vcount_r <= 10'd0;
        end else begin
          vcount_r <= vcount_r + 10'd1;
        end
      end else begin
        hcount_r <= hcount_r + 8'd1;
      end
    end
  end

  // Registered outputs, one tick behind the counters they were decoded from
  always_ff @(posedge clkvideo or posedge reset) begin
    if (reset) begin
      csync_r       <= 1'b1;
      v_out_r       <= 1'b0;
      hblank_r      <= 1'b1;
      vblank_r      <= 1'b1;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else if (bus.ce) begin
      csync_r       <= csync_s;
      v_out_r       <= video_s;
      hblank_r      <= hblank_s;
      vblank_r      <= vblank_s;
      line_start_r  <= (hcount_r == 8'd0);
      frame_start_r <= (hcount_r == 8'd0) && (vcount_r == 10'd0);
    end
  end

  assign bus.csync       = csync_r;
  assign bus.v_out       = v_out_r;
  assign bus.hcount      = hcount_r;
  assign bus.vcount      = vcount_r;
  assign bus.hblank      = hblank_r;
  assign bus.vblank      = vblank_r;
  assign bus.line_start  = line_start_r;
  assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_csync_gen.sv
// Scoreboard bench for csync_gen: stimulus pushes expected per-tick outputs, a monitor
// pops and compares on every ce tick; frame-level statistics are checked against constants.
module tb_csync_gen;

  typedef struct packed {
    logic [7:0] hc;
    logic [9:0] vc;
    logic       cs;
    logic       hb;
    logic       vb;
    logic       vo;
    logic       ls;
    logic       fs;
  } obs_t;

  logic clkvideo = 1'b0;
  logic reset;

  csync_gen_if bus ();

  csync_gen dut (
    .clkvideo (clkvideo),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clkvideo = ~clkvideo;

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t q[$];
  obs_t reset_obs;
  logic [7:0] m_hc;
  logic [9:0] m_vc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t sample_dut();
    obs_t s;
    s.hc = bus.hcount;
    s.vc = bus.vcount;
    s.cs = bus.csync;
    s.hb = bus.hblank;
    s.vb = bus.vblank;
    s.vo = bus.v_out;
    s.ls = bus.line_start;
    s.fs = bus.frame_start;
    return s;
  endfunction

  // Reference: outputs after a tick taken at position (hc, vc), with hand-set timing constants
  function automatic obs_t model(input logic [7:0] hc, input logic [9:0] vc, input logic vin);
    obs_t e;
    logic vs;
    vs   = (vc >= 10'd258) && (vc <= 10'd260);
    e.cs = vs ? (hc >= 8'd120) : (hc >= 8'd8);
    e.hb = (hc < 8'd12);
    e.vb = (vc < 10'd13) || (vc >= 10'd258);
    e.vo = vin & ~e.hb & ~e.vb;
    e.ls = (hc == 8'd0);
    e.fs = (hc == 8'd0) && (vc == 10'd0);
    if (hc == 8'd127) begin
      e.hc = 8'd0;
      e.vc = (vc == 10'd261) ? 10'd0 : vc + 10'd1;
    end else begin
      e.hc = hc + 8'd1;
      e.vc = vc;
    end
    return e;
  endfunction

  // One clock from a negedge to the next; a ce tick pushes its expected result
  task automatic tick(input logic ce_v, input logic vin);
    obs_t e;
    bus.ce   = ce_v;
    bus.v_in = vin;
    if (ce_v) begin
      e = model(m_hc, m_vc, vin);
      q.push_back(e);
      m_hc = e.hc;
      m_vc = e.vc;
    end
    @(posedge clkvideo);
    @(negedge clkvideo);
  endtask

  // Monitor: reset values while in reset, scoreboard pop on ce ticks, hold on idle cycles
  initial begin
    obs_t cur;
    obs_t prev;
    obs_t e;
    logic ce_c;
    logic rst_c;
    prev = '0;
    forever begin
      @(posedge clkvideo);
      ce_c  = bus.ce;
      rst_c = reset;
      #1;
      cur = sample_dut();
      if (rst_c) begin
        check("reset_hold", 32'(cur), 32'(reset_obs));
      end else if (ce_c) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_empty: actual=tick expected=no tick at t=%0t", $time);
        end else begin
          e = q.pop_front();
          check("tick", 32'(cur), 32'(e));
        end
      end else begin
        check("ce_hold", 32'(cur), 32'(prev));
      end
      prev = cur;
    end
  end

  initial begin
    obs_t cur;
    int   run;
    int   n120, n8, nother, nwin, edges, vo_cnt, ls_cnt, fs_cnt, fs_first, fs_period;
    logic prev_cs;

    reset_obs = '{hc: 8'd0, vc: 10'd0, cs: 1'b1, hb: 1'b1, vb: 1'b1, vo: 1'b0, ls: 1'b0, fs: 1'b0};
    reset      = 1'b1;
    bus.ce     = 1'b0;
    bus.v_in   = 1'b0;
    m_hc       = 8'd0;
    m_vc       = 10'd0;
    @(negedge clkvideo);
    @(negedge clkvideo);
    check("reset_values", 32'(sample_dut()), 32'(reset_obs));
    reset = 1'b0;

    // One full frame plus one tick with v_in=1, gathering sync/video statistics
    run = 0; n120 = 0; n8 = 0; nother = 0; nwin = 0; edges = 0;
    vo_cnt = 0; ls_cnt = 0; fs_cnt = 0; fs_first = 0; fs_period = 0;
    prev_cs = 1'b1;
    for (int i = 1; i <= 33537; i++) begin
      tick(1'b1, 1'b1);
      cur = sample_dut();
      if (cur.fs) begin
        fs_cnt++;
        if (fs_cnt == 1) fs_first = i;
        else fs_period = i - fs_first;
      end
      if (i <= 33536) begin
        if (cur.ls) ls_cnt++;
        if (cur.vo) vo_cnt++;
        if (!cur.cs) begin
          if (prev_cs) edges++;
          run++;
        end else if (run > 0) begin
          if (run == 120) n120++;
          else if (run == 8) n8++;
          else nother++;
          if (run >= 64 && run <= 191) nwin++;
          run = 0;
        end
        prev_cs = cur.cs;
      end
    end
    check("vsync_runs_120", 32'(n120), 32'd3);
    check("hsync_runs_8", 32'(n8), 32'd259);
    check("other_runs", 32'(nother), 32'd0);
    check("falling_edges", 32'(edges), 32'd262);
    check("frame_sync_window", 32'(nwin), 32'd3);
    check("v_out_total", 32'(vo_cnt), 32'd28420);
    check("line_starts", 32'(ls_cnt), 32'd262);
    check("frame_starts", 32'(fs_cnt), 32'd2);
    check("frame_period", 32'(fs_period), 32'd33536);

    // ce on one cycle in three, into the visible area, with a patterned pixel
    for (int i = 0; i < 2048; i++) begin
      tick(1'b1, m_hc[2]);
      tick(1'b0, ~m_hc[2]);
      tick(1'b0, m_hc[2]);
    end

    // Move to hcount=70, vcount=100, then assert reset between clock edges
    for (int i = 0; i < 40000; i++) begin
      if (m_hc == 8'd70 && m_vc == 10'd100) break;
      tick(1'b1, 1'b1);
    end
    check("reach_70_100", {14'd0, bus.vcount, bus.hcount}, {14'd0, 10'd100, 8'd70});
    #2 reset = 1'b1;
    #1 check("async_reset", 32'(sample_dut()), 32'(reset_obs));
    @(posedge clkvideo);
    @(posedge clkvideo);
    @(negedge clkvideo);
    reset = 1'b0;
    m_hc  = 8'd0;
    m_vc  = 10'd0;
    for (int i = 1; i <= 200; i++) begin
      tick(1'b1, 1'b0);
      if (i <= 3) check("post_reset_hcount", 32'(bus.hcount), 32'(i));
    end

    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("sb_drain", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
